symbol_shift_pipe: RTL and testbench

Pipelined, parametrised symbol shifter: successor to the fixed 10×5-bit combinational right shifter. Shifts a NUM_SYM-symbol word by 0..MAX_SHIFT whole symbols, left or right, with fill-symbol insertion or optional rotation. Sits in the datapath between the symbol packer and the framing stage. Two register stages with valid/ready flow control, out-of-range shift detection and a saturating error counter.

---
 rtl/symbol_shift_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_symbol_shift_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_shift_pipe.sv
// Two-stage valid/ready symbol shifter: whole-symbol left/right shift with fill,
// out-of-range detection and a saturating error counter. Rotate datapath built only
// when SYMBOL_SHIFT_ROTATE_EN is defined; otherwise mode_i is ignored (fill mode).
module symbol_shift_pipe #(
  parameter int SYM_W     = 5,
  parameter int NUM_SYM   = 10,
  parameter int MAX_SHIFT = 4,
  parameter int SHIFT_W   = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SYM_W*NUM_SYM-1:0]   in_data_i,
  input  logic [SHIFT_W-1:0]         shift_i,
  input  logic                       dir_i,
  input  logic                       mode_i,
  input  logic [SYM_W-1:0]           fill_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SYM_W*NUM_SYM-1:0]   out_data_o,
  output logic                       out_err_o,
  output logic [ERR_CNT_W-1:0]       err_cnt_o
);

  localparam int W = SYM_W * NUM_SYM;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT_C = SHIFT_W'(MAX_SHIFT);
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  logic                 s2_load_s;
  logic                 in_ready_s;
  logic                 in_fire_s;
  logic                 oor_s;

  logic                 s1_valid_q, s1_valid_d;
  logic [W-1:0]         s1_data_q,  s1_data_d;
  logic [SHIFT_W-1:0]   s1_shift_q, s1_shift_d;
  logic                 s1_dir_q,   s1_dir_d;
  logic [SYM_W-1:0]     s1_fill_q,  s1_fill_d;
  logic                 s1_err_q,   s1_err_d;
`ifdef SYMBOL_SHIFT_ROTATE_EN
  logic                 s1_mode_q,  s1_mode_d;
`else
  logic                 unused_mode_s;
`endif

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q,  out_data_d;
  logic                 out_err_q,   out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  // Candidate results indexed by shift amount; entry 0 is the pass-through word.
  logic [W-1:0]         rf_s [MAX_SHIFT+1];
  logic [W-1:0]         lf_s [MAX_SHIFT+1];
`ifdef SYMBOL_SHIFT_ROTATE_EN
  logic [W-1:0]         rr_s [MAX_SHIFT+1];
  logic [W-1:0]         rl_s [MAX_SHIFT+1];
`endif
  logic [W-1:0]         res_s;

  assign s2_load_s  = ~out_valid_q | out_ready_i;
  assign in_ready_s = ~s1_valid_q | s2_load_s;
  assign in_fire_s  = in_valid_i & in_ready_s;
  assign oor_s      = (shift_i > MAX_SHIFT_C);

`ifndef SYMBOL_SHIFT_ROTATE_EN
  assign unused_mode_s = mode_i;
`endif

  for (genvar a = 0; a <= MAX_SHIFT; a++) begin : g_amt
    for (genvar k = 0; k < NUM_SYM; k++) begin : g_sym
      if (k + a < NUM_SYM) begin : g_rin
        assign rf_s[a][k*SYM_W +: SYM_W] = s1_data_q[(k+a)*SYM_W +: SYM_W];
      end else begin : g_rfill
        assign rf_s[a][k*SYM_W +: SYM_W] = s1_fill_q;
      end
      if (k >= a) begin : g_lin
        assign lf_s[a][k*SYM_W +: SYM_W] = s1_data_q[(k-a)*SYM_W +: SYM_W];
      end else begin : g_lfill
        assign lf_s[a][k*SYM_W +: SYM_W] = s1_fill_q;
      end
`ifdef SYMBOL_SHIFT_ROTATE_EN
      assign rr_s[a][k*SYM_W +: SYM_W] = s1_data_q[((k+a) % NUM_SYM)*SYM_W +: SYM_W];
      assign rl_s[a][k*SYM_W +: SYM_W] = s1_data_q[((k-a+NUM_SYM) % NUM_SYM)*SYM_W +: SYM_W];
`endif
    end
  end

  // Stage-2 result select; an out-of-range shift overrides direction and mode.
  always_comb begin
    res_s = '0;
    if (s1_err_q) begin
      res_s = {NUM_SYM{s1_fill_q}};
    end else begin
`ifdef SYMBOL_SHIFT_ROTATE_EN
      if (s1_mode_q) begin
        res_s = s1_dir_q ? rl_s[s1_shift_q] : rr_s[s1_shift_q];
      end else begin
        res_s = s1_dir_q ? lf_s[s1_shift_q] : rf_s[s1_shift_q];
      end
`else
      res_s = s1_dir_q ? lf_s[s1_shift_q] : rf_s[s1_shift_q];
`endif
    end
  end

  // Stage-1 capture next state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_shift_d = s1_shift_q;
    s1_dir_d   = s1_dir_q;
    s1_fill_d  = s1_fill_q;
    s1_err_d   = s1_err_q;
`ifdef SYMBOL_SHIFT_ROTATE_EN
    s1_mode_d  = s1_mode_q;
`endif
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data_i;
      s1_shift_d = shift_i;
      s1_dir_d   = dir_i;
      s1_fill_d  = fill_i;
      s1_err_d   = oor_s;
`ifdef SYMBOL_SHIFT_ROTATE_EN
      s1_mode_d  = mode_i;
`endif
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage-2 output next state and saturating error counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (s2_load_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res_s;
        out_err_d  = s1_err_q;
      end else begin
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (in_fire_s && oor_s && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shift_q  <= '0;
      s1_dir_q    <= 1'b0;
      s1_fill_q   <= '0;
      s1_err_q    <= 1'b0;
`ifdef SYMBOL_SHIFT_ROTATE_EN
      s1_mode_q   <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_shift_q  <= s1_shift_d;
      s1_dir_q    <= s1_dir_d;
      s1_fill_q   <= s1_fill_d;
      s1_err_q    <= s1_err_d;
`ifdef SYMBOL_SHIFT_ROTATE_EN
      s1_mode_q   <= s1_mode_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_symbol_shift_pipe.sv
// Scoreboard bench for symbol_shift_pipe: expected words are queued on acceptance
// and compared when the DUT emits them; follows SYMBOL_SHIFT_ROTATE_EN like the DUT.
module tb_symbol_shift_pipe;
  localparam int SYM_W     = 5;
  localparam int NUM_SYM   = 10;
  localparam int MAX_SHIFT = 4;
  localparam int SHIFT_W   = 3;
  localparam int ERR_CNT_W = 8;
  localparam int W         = SYM_W * NUM_SYM;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic [SHIFT_W-1:0]   shift;
  logic                 dir;
  logic                 mode;
  logic [SYM_W-1:0]     fill;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_cnt = 0;
  logic hold_v = 1'b0;
  logic [W:0] hold_w = '0;
  logic rand_on = 1'b0;

  symbol_shift_pipe #(
    .SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .MAX_SHIFT(MAX_SHIFT),
    .SHIFT_W(SHIFT_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .shift_i(shift), .dir_i(dir), .mode_i(mode), .fill_i(fill),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_err_o(out_err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] make_word(input int base);
    logic [W-1:0] r = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      r = r | (W'((base + k) % 32) << (k * SYM_W));
    end
    return r;
  endfunction

  // Reference: build each output symbol from its source position.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input bit left,
                                         input bit md, input logic [SYM_W-1:0] f);
    logic [W-1:0] r = '0;
    logic [W-1:0] tmp;
    logic [SYM_W-1:0] sym;
    bit rot;
    int src;
`ifdef SYMBOL_SHIFT_ROTATE_EN
    rot = md;
`else
    rot = 1'b0;
`endif
    for (int k = 0; k < NUM_SYM; k++) begin
      if (s > MAX_SHIFT) begin
        sym = f;
      end else begin
        src = left ? (k - s) : (k + s);
        if (src >= 0 && src < NUM_SYM) begin
          tmp = d >> (src * SYM_W);
          sym = tmp[SYM_W-1:0];
        end else if (rot) begin
          tmp = d >> (((src + NUM_SYM) % NUM_SYM) * SYM_W);
          sym = tmp[SYM_W-1:0];
        end else begin
          sym = f;
        end
      end
      r = r | (W'(sym) << (k * SYM_W));
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input int s, input bit dr, input bit md,
                      input logic [SYM_W-1:0] f);
    int waited = 0;
    exp_t e;
    in_valid = 1'b1; in_data = d; shift = SHIFT_W'(s); dir = dr; mode = md; fill = f;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.err  = (s > MAX_SHIFT);
      e.data = model(d, s, dr, md, f);
      sb_q.push_back(e);
      if (s > MAX_SHIFT && model_cnt < 255) model_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("drain", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard compare on transfer and hold stability during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_data", 64'({out_err, out_data}), 64'(hold_w));
      end
      hold_v = out_valid && !out_ready;
      hold_w = {out_err, out_data};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("out_data", 64'(out_data), 64'(e.data));
          check_eq("out_err", 64'(out_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0; dir = 1'b0;
    mode = 1'b0; fill = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_err", 64'(out_err), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Right fill, shift 2, with two-register latency check.
    send(make_word(0), 2, 1'b0, 1'b0, 5'h1F);
    @(negedge clk);
    check_eq("lat_stage1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_stage2", 64'(out_valid), 64'd1);
    check_eq("right2_sym9", 64'(out_data[9*SYM_W +: SYM_W]), 64'h1F);
    check_eq("right2_sym0", 64'(out_data[SYM_W-1:0]), 64'd2);
    drain();

    // Out of range: replicated fill, error flag, counter step.
    send(make_word(0), 5, 1'b0, 1'b0, 5'h0A);
    @(negedge clk);
    check_eq("err_cnt_first", 64'(err_cnt), 64'(model_cnt));
    drain();

    send(make_word(1), 1, 1'b1, 1'b0, 5'h00);
    send(make_word(0), 3, 1'b0, 1'b1, 5'h15);
    send(make_word(3), 2, 1'b1, 1'b1, 5'h07);
    send(make_word(7), 0, 1'b1, 1'b1, 5'h11);
    send(make_word(9), 4, 1'b1, 1'b0, 5'h1E);
    send(make_word(4), 4, 1'b0, 1'b1, 5'h02);
    drain();

    // Stall: three back-to-back words with out_ready low for three cycles.
    out_ready = 1'b0;
    fork
      begin
        send(make_word(10), 1, 1'b0, 1'b0, 5'h01);
        send(make_word(20), 2, 1'b1, 1'b0, 5'h02);
        send(make_word(5), 6, 1'b0, 1'b0, 5'h03);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(W'({$urandom, $urandom}), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), SYM_W'($urandom_range(0, 31)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check_eq("err_cnt_random", 64'(err_cnt), 64'(model_cnt));
    @(posedge clk); #1;

    // Reset with two words in flight: nothing stale may emerge.
    send(make_word(2), 1, 1'b0, 1'b0, 5'h04);
    send(make_word(3), 7, 1'b0, 1'b0, 5'h05);
    rst_n = 1'b0;
    sb_q.delete();
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("flush_idle", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Saturation: 300 out-of-range words.
    send(make_word(0), 5, 1'b0, 1'b0, 5'h0A);
    @(negedge clk);
    check_eq("sat_first", 64'(err_cnt), 64'd1);
    @(posedge clk); #1;
    for (int i = 1; i < 300; i++) begin
      send(make_word(i), 5 + (i % 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           SYM_W'(i));
    end
    drain();
    @(negedge clk);
    check_eq("sat_model", 64'(err_cnt), 64'(model_cnt));
    check_eq("sat_ff", 64'(err_cnt), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
